// File: rtl/imm_gen.sv
// imm_gen -- RV32I immediate generator for the decode stage.
//
// Extracts the immediate field of an instruction in the format picked by
// imm_sel and sign- or zero-extends it to XLEN bits. The combinational result
// drives same-cycle ALU/branch logic. A registered copy feeds the
// decode->execute pipeline register.
//
// Build option: when IMMGEN_AUTODECODE_EN is defined, imm_sel==7 derives the
// format from the opcode in instr[6:0]. When it is undefined, imm_sel==7 always
// means "no immediate" and the opcode decoder is not built.
//
// Ports:
//   clk      in   1     rising-edge clock
//   rst      in   1     synchronous active-high reset (clears imm_q, sel_err)
//   instr    in   XLEN  instruction word
//   imm_sel  in   3     0 I, 1 S, 2 B, 3 U, 4 J, 5 SHAMT, 6 ZIMM, 7 AUTO
//   out      out  XLEN  combinational immediate (not affected by rst)
//   imm_q    out  XLEN  out registered one edge later
//   sel_err  out  1     registered pulse: imm_sel==7 resolved to no immediate
module imm_gen #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instr,
  input  logic [2:0]      imm_sel,
  output logic [XLEN-1:0] out,
  output logic [XLEN-1:0] imm_q,
  output logic            sel_err
);

  if (XLEN != 32) begin : g_xlen_check
    $error("imm_gen: only XLEN=32 is supported");
  end

  typedef enum logic [2:0] {
    FMT_I     = 3'd0,
    FMT_S     = 3'd1,
    FMT_B     = 3'd2,
    FMT_U     = 3'd3,
    FMT_J     = 3'd4,
    FMT_SHAMT = 3'd5,
    FMT_ZIMM  = 3'd6,
    FMT_NONE  = 3'd7
  } fmt_e;

  fmt_e            fmt;
  logic [XLEN-1:0] imm_d;
  logic            sel_err_d;
  logic            sel_err_q;

`ifdef IMMGEN_AUTODECODE_EN
  fmt_e auto_fmt;

  always_comb begin
    auto_fmt = FMT_NONE;
    unique case (instr[6:0])
      7'h03, 7'h67, 7'h73: auto_fmt = FMT_I;
      // OP-IMM shifts (SLLI/SRLI/SRAI) carry a shift amount, not an I immediate.
      7'h13:               auto_fmt = (instr[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
      7'h23:               auto_fmt = FMT_S;
      7'h63:               auto_fmt = FMT_B;
      7'h37, 7'h17:        auto_fmt = FMT_U;
      7'h6F:               auto_fmt = FMT_J;
      default:             auto_fmt = FMT_NONE;
    endcase
  end
`else
  // Opcode bits only matter to the auto decoder.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];
`endif

  always_comb begin
    fmt = fmt_e'(imm_sel);
    if (imm_sel == 3'd7) begin
`ifdef IMMGEN_AUTODECODE_EN
      fmt = auto_fmt;
`else
      fmt = FMT_NONE;
`endif
    end
  end

  // Every signed format extends from instr[31].
  always_comb begin
    out = '0;
    unique case (fmt)
      FMT_I:     out = {{(XLEN-12){instr[31]}}, instr[31:20]};
      FMT_S:     out = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:     out = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                        instr[30:25], instr[11:8], 1'b0};
      FMT_U:     out = {instr[31:12], 12'b0};
      FMT_J:     out = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                        instr[20], instr[30:21], 1'b0};
      FMT_SHAMT: out = {{(XLEN-5){1'b0}}, instr[24:20]};
      FMT_ZIMM:  out = {{(XLEN-5){1'b0}}, instr[19:15]};
      default:   out = '0;
    endcase
  end

  assign imm_d     = out;
  assign sel_err_d = (imm_sel == 3'd7) && (fmt == FMT_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      imm_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      imm_q     <= imm_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_imm_gen.sv
module tb_imm_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [2:0]  imm_sel;
  logic [31:0] out;
  logic [31:0] imm_q;
  logic        sel_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] imm;
    logic        err;
    string       nm;
  } exp_t;

  exp_t sb_q[$];

  imm_gen #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .instr   (instr),
    .imm_sel (imm_sel),
    .out     (out),
    .imm_q   (imm_q),
    .sel_err (sel_err)
  );

  always #5 clk = ~clk;

  // Reference: format chosen by imm_sel (or by opcode for AUTO), -1 = none.
  function automatic int ref_fmt(logic [31:0] ins, logic [2:0] sel);
    int op;
    int f3;
    if (sel != 3'd7) return int'(sel);
`ifdef IMMGEN_AUTODECODE_EN
    op = int'(ins & 32'h7F);
    f3 = int'((ins >> 12) & 32'h7);
    if (op == 'h13 && (f3 == 1 || f3 == 5)) return 5;
    if (op == 'h03 || op == 'h13 || op == 'h67 || op == 'h73) return 0;
    if (op == 'h23) return 1;
    if (op == 'h63) return 2;
    if (op == 'h37 || op == 'h17) return 3;
    if (op == 'h6F) return 4;
    return -1;
`else
    op = 0;
    f3 = 0;
    return -1 + op + f3;
`endif
  endfunction

  // Reference immediate built from field values with shifts and masks.
  function automatic logic [31:0] ref_imm(logic [31:0] ins, int fmt);
    int s;
    int sgn;
    s   = int'(ins);
    sgn = s >>> 31;   // 0 or -1
    case (fmt)
      0: return 32'(s >>> 20);
      1: return 32'((sgn << 11) | int'(((ins >> 25) & 32'h3F) << 5) | int'((ins >> 7) & 32'h1F));
      2: return 32'((sgn << 12) | int'(((ins >> 7) & 32'h1) << 11)
                    | int'(((ins >> 25) & 32'h3F) << 5) | int'(((ins >> 8) & 32'hF) << 1));
      3: return ins & 32'hFFFFF000;
      4: return 32'((sgn << 20) | int'(((ins >> 12) & 32'hFF) << 12)
                    | int'(((ins >> 20) & 32'h1) << 11) | int'(((ins >> 21) & 32'h3FF) << 1));
      5: return (ins >> 20) & 32'h1F;
      6: return (ins >> 15) & 32'h1F;
      default: return 32'h0;
    endcase
  endfunction

  // Drive one cycle, check the combinational output, queue the registered result.
  task automatic step(input logic r, input logic [31:0] ins, input logic [2:0] sel,
                      input logic use_const, input logic [31:0] const_out, input string nm);
    int          f;
    logic [31:0] m_out;
    exp_t        e;
    @(negedge clk);
    rst     = r;
    instr   = ins;
    imm_sel = sel;
    #1;
    f     = ref_fmt(ins, sel);
    m_out = ref_imm(ins, f);
    n_cmp++;
    if (use_const) begin
      if (out !== const_out) begin
        n_bad++;
        $display("FAIL %s out: got %08h want %08h", nm, out, const_out);
      end
    end else if (out !== m_out) begin
      n_bad++;
      $display("FAIL %s out: got %08h want %08h (instr %08h sel %0d)", nm, out, m_out, ins, sel);
    end
    e.imm = r ? 32'h0 : m_out;
    e.err = r ? 1'b0 : (sel == 3'd7 && f < 0);
    e.nm  = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: each edge presents a new registered result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (imm_q !== e.imm || sel_err !== e.err) begin
          n_bad++;
          $display("FAIL %s reg: imm_q %08h sel_err %b, want %08h %b",
                   e.nm, imm_q, sel_err, e.imm, e.err);
        end
      end
    end
  end

  logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h7F};

  initial begin
    logic [31:0] ri;
    logic [2:0]  rs;
    logic        rr;
    int          budget;
    rst = 1'b1; instr = '0; imm_sel = '0;

    step(1'b1, 32'h0, 3'd0, 1'b1, 32'h0, "rst0");
    step(1'b1, 32'h0, 3'd0, 1'b1, 32'h0, "rst1");

    step(1'b0, 32'hFFC4A303, 3'd0, 1'b1, 32'hFFFFFFFC, "sel0_I");
    step(1'b0, 32'h0064A423, 3'd1, 1'b1, 32'h00000008, "sel1_S");
    step(1'b0, 32'hFE420AE3, 3'd2, 1'b1, 32'hFFFFFFF4, "sel2_B");
    step(1'b0, 32'h12345037, 3'd3, 1'b1, 32'h12345000, "sel3_U");
    step(1'b0, 32'h0080006F, 3'd4, 1'b1, 32'h00000008, "sel4_J");
    step(1'b0, 32'h41F4D493, 3'd5, 1'b1, 32'h0000001F, "sel5_SHAMT");
    step(1'b0, 32'h000F8073, 3'd6, 1'b1, 32'h0000001F, "sel6_ZIMM");
    // Reset mid-stream with live inputs: out stays valid, registers clear.
    step(1'b1, 32'hFFC4A303, 3'd0, 1'b1, 32'hFFFFFFFC, "mid_rst");
    step(1'b0, 32'h80000000, 3'd4, 1'b1, 32'hFFF00000, "after_rst_J");
`ifdef IMMGEN_AUTODECODE_EN
    step(1'b0, 32'hFE420AE3, 3'd7, 1'b1, 32'hFFFFFFF4, "auto_B");
    step(1'b0, 32'h00B50533, 3'd7, 1'b1, 32'h00000000, "auto_none");
    step(1'b0, 32'h41F4D493, 3'd7, 1'b1, 32'h0000001F, "auto_shamt");
`else
    step(1'b0, 32'hFE420AE3, 3'd7, 1'b1, 32'h00000000, "auto_off_B");
    step(1'b0, 32'h00B50533, 3'd7, 1'b1, 32'h00000000, "auto_off_R");
`endif
    step(1'b0, 32'h00B50533, 3'd0, 1'b1, 32'h0000000B, "err_clear");

    for (int i = 0; i < 400; i++) begin
      ri = $urandom;
      rs = 3'($urandom_range(0, 7));
      rr = ($urandom_range(0, 15) == 0);
      if (rs == 3'd7 && $urandom_range(0, 3) != 0)
        ri = {ri[31:7], ops[$urandom_range(0, 11)]};
      step(rr, ri, rs, 1'b0, 32'h0, "rand");
    end

    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results never observed, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
